// File: rtl/iomem_spi_log_if.sv
// picosoc iomem bus bundle: master drives the request, slave returns a one-cycle ready with read data.
interface iomem_spi_log_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/iomem_spi_log.sv
// iomem peripheral: GPIO register plus a FIFO log of SPI commands seen by the spy core,
// with overflow count, flush and a level interrupt while the log is non-empty.
module iomem_spi_log #(
  parameter logic [7:0] BASE  = 8'h03,
  parameter int         DEPTH = 16
) (
  input  logic                clk,
  input  logic                resetn,
  iomem_spi_log_if.slave      bus,
  input  logic                cmd_strobe,
  input  logic [7:0]          cmd,
  input  logic [31:0]         cmd_addr,
  input  logic [11:0]         cmd_len,
  output logic [31:0]         gpio_out,
  output logic                irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // entry layout: {cmd[51:44], addr[43:12], len[11:0]}
  logic [51:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [31:0]   overflow;
  logic [1:0]    ctrl, ctrl_nxt;
  logic [2:0]    idx;
  logic [51:0]   head;
  logic [31:0]   rd_mux;
  logic          sel, is_wr, is_rd, empty, full, pop, flush, push_req, push, drop;
  logic          unused_bits;

  assign sel      = bus.valid && !bus.ready && (bus.addr[31:24] == BASE);
  assign idx      = bus.addr[4:2];
  assign is_wr    = sel && (bus.wstrb != 4'b0000);
  assign is_rd    = sel && (bus.wstrb == 4'b0000);
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign head     = mem[rd_ptr];
  assign pop      = is_rd && (idx == 3'd3) && !empty;
  assign flush    = is_wr && (idx == 3'd5) && bus.wstrb[3] && bus.wdata[31];
  assign push_req = cmd_strobe && ctrl[0];
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push     = push_req && !flush && (!full || pop);
  assign drop     = push_req && !flush && full && !pop;

  assign unused_bits = ^{bus.addr[23:5], bus.addr[1:0]};

  always_comb begin
    ctrl_nxt = ctrl;
    if (is_wr && (idx == 3'd5) && bus.wstrb[0]) ctrl_nxt = bus.wdata[1:0];
    count_nxt = count;
    if (flush) count_nxt = '0;
    else       count_nxt = count + CW'(push) - CW'(pop);
  end

  always_comb begin
    rd_mux = 32'h0;
    case (idx)
      3'd0: rd_mux = gpio_out;
      3'd1: rd_mux = {14'h0, full, empty, {(16-CW){1'b0}}, count};
      3'd2: rd_mux = empty ? 32'h0 : head[43:12];
      3'd3: rd_mux = empty ? 32'h0 : {head[51:44], 12'h0, head[11:0]};
      3'd4: rd_mux = overflow;
      3'd5: rd_mux = {30'h0, ctrl};
      default: rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn && push) mem[wr_ptr] <= {cmd, cmd_addr, cmd_len};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.ready <= 1'b0;
      bus.rdata <= 32'h0;
      gpio_out  <= 32'h0;
      ctrl      <= 2'b01;
      overflow  <= 32'h0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      irq       <= 1'b0;
    end else begin
      bus.ready <= sel;
      bus.rdata <= sel ? rd_mux : 32'h0;
      if (is_wr && (idx == 3'd0)) begin
        for (int b = 0; b < 4; b++)
          if (bus.wstrb[b]) gpio_out[8*b +: 8] <= bus.wdata[8*b +: 8];
      end
      ctrl <= ctrl_nxt;
      if (is_wr && (idx == 3'd4))             overflow <= 32'h0;
      else if (drop && (overflow != '1))      overflow <= overflow + 32'd1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      // built from next-state values so irq tracks the FIFO with one cycle of latency
      irq <= ctrl_nxt[1] && (count_nxt != '0);
    end
  end
endmodule

// File: tb/tb_iomem_spi_log.sv
// Directed bench for iomem_spi_log: register table plus push/pop/overflow/flush/irq sequences.
module tb_iomem_spi_log;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_strobe = 1'b0;
  logic [7:0]  cmd = 8'h0;
  logic [31:0] cmd_addr = 32'h0;
  logic [11:0] cmd_len = 12'h0;
  logic [31:0] gpio_out;
  logic        irq;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] r;
  int          lat;

  iomem_spi_log_if b ();

  iomem_spi_log #(.BASE(8'h03), .DEPTH(16)) dut (
    .clk(clk), .resetn(resetn), .bus(b),
    .cmd_strobe(cmd_strobe), .cmd(cmd), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  off;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // issue one access; stb pulses cmd_strobe in the selection cycle
  task automatic acc(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] wd,
                     input logic stb, output logic [31:0] rd);
    int n;
    b.valid = 1'b1; b.addr = {8'h03, 16'h0, off}; b.wstrb = strb; b.wdata = wd;
    cmd_strobe = stb;
    n = 0;
    do begin
      @(posedge clk); #1;
      cmd_strobe = 1'b0;
      n++;
    end while (!b.ready && n < 8);
    check("ready_latency", 32'(n), 32'd1);
    rd = b.rdata;
    b.valid = 1'b0; b.wstrb = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] v;
    acc(off, 4'h0, 32'h0, 1'b0, v);
    check(name, v, exp);
  endtask

  task automatic wr(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] wd);
    logic [31:0] v;
    acc(off, strb, wd, 1'b0, v);
  endtask

  task automatic pulse(input logic [7:0] c, input logic [31:0] a, input logic [11:0] l);
    cmd = c; cmd_addr = a; cmd_len = l; cmd_strobe = 1'b1;
    @(posedge clk); #1;
    cmd_strobe = 1'b0;
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{8'h04, 4'h0, 32'h0,         1, 32'h0001_0000};
    tbl[1]  = '{8'h14, 4'h0, 32'h0,         1, 32'h0000_0001};
    tbl[2]  = '{8'h00, 4'h5, 32'hAABB_CCDD, 0, 32'h0};
    tbl[3]  = '{8'h00, 4'h0, 32'h0,         1, 32'h00BB_00DD};
    tbl[4]  = '{8'h04, 4'hF, 32'h1234_5678, 0, 32'h0};
    tbl[5]  = '{8'h04, 4'h0, 32'h0,         1, 32'h0001_0000};
    tbl[6]  = '{8'h1C, 4'hF, 32'hFFFF_FFFF, 0, 32'h0};
    tbl[7]  = '{8'h18, 4'h0, 32'h0,         1, 32'h0};
    tbl[8]  = '{8'h08, 4'h0, 32'h0,         1, 32'h0};
    tbl[9]  = '{8'h0C, 4'h0, 32'h0,         1, 32'h0};
    tbl[10] = '{8'h14, 4'h1, 32'h0000_0003, 0, 32'h0};
    tbl[11] = '{8'h14, 4'h0, 32'h0,         1, 32'h0000_0003};
    tbl[12] = '{8'h14, 4'hF, 32'h8000_0001, 0, 32'h0};
    tbl[13] = '{8'h14, 4'h0, 32'h0,         1, 32'h0000_0001};

    b.valid = 1'b0; b.addr = 32'h0; b.wstrb = 4'h0; b.wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    check("reset_gpio", gpio_out, 32'h0);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_ready", 32'(b.ready), 32'd0);

    for (int i = 0; i < 14; i++) begin
      acc(tbl[i].off, tbl[i].wstrb, tbl[i].wdata, 1'b0, r);
      if (tbl[i].chk) check($sformatf("table_%0d", i), r, tbl[i].exp);
    end
    check("gpio_out", gpio_out, 32'h00BB_00DD);

    // foreign address must never be acknowledged
    b.valid = 1'b1; b.addr = 32'h0400_0014; b.wstrb = 4'h0;
    lat = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (b.ready) lat++;
    end
    b.valid = 1'b0;
    check("foreign_no_ready", 32'(lat), 32'd0);
    @(posedge clk); #1;

    // single push, STATUS selected in the very next cycle
    pulse(8'h03, 32'h0012_3400, 12'h100);
    rd_chk("status_after_push", 8'h04, 32'h0000_0001);
    rd_chk("head_addr", 8'h08, 32'h0012_3400);
    rd_chk("head_cmd", 8'h0C, 32'h0300_0100);
    rd_chk("status_empty", 8'h04, 32'h0001_0000);

    // 20 back-to-back strobes into 16 entries
    for (int i = 0; i < 20; i++) begin
      cmd = 8'(i + 1); cmd_addr = 32'h1000 + 32'(i); cmd_len = 12'(3 * i + 1);
      cmd_strobe = 1'b1;
      @(posedge clk); #1;
    end
    cmd_strobe = 1'b0;
    rd_chk("status_full", 8'h04, 32'h0002_0010);
    rd_chk("overflow_4", 8'h10, 32'h0000_0004);

    // full: pop and push in the same cycle
    cmd = 8'hEE; cmd_addr = 32'h0000_000E; cmd_len = 12'h00E;
    acc(8'h0C, 4'h0, 32'h0, 1'b1, r);
    check("simul_pop", r, 32'h0100_0001);
    rd_chk("simul_status", 8'h04, 32'h0002_0010);
    rd_chk("simul_overflow", 8'h10, 32'h0000_0004);

    for (int i = 1; i < 16; i++) begin
      rd_chk($sformatf("drain_addr_%0d", i), 8'h08, 32'h1000 + 32'(i));
      rd_chk($sformatf("drain_cmd_%0d", i), 8'h0C, {8'(i + 1), 12'h0, 12'(3 * i + 1)});
    end
    rd_chk("drain_addr_last", 8'h08, 32'h0000_000E);
    rd_chk("drain_cmd_last", 8'h0C, 32'hEE00_000E);
    rd_chk("drained_status", 8'h04, 32'h0001_0000);

    wr(8'h10, 4'h1, 32'h0);
    rd_chk("overflow_clear", 8'h10, 32'h0);

    // flush with irq enabled; a strobe in the flush cycle is dropped silently
    wr(8'h14, 4'h1, 32'h3);
    for (int i = 0; i < 3; i++) pulse(8'h20, 32'h2000, 12'h5);
    check("irq_set", 32'(irq), 32'd1);
    acc(8'h14, 4'hF, 32'h8000_0003, 1'b1, r);
    check("irq_after_flush", 32'(irq), 32'd0);
    rd_chk("flush_status", 8'h04, 32'h0001_0000);
    rd_chk("flush_overflow", 8'h10, 32'h0);
    rd_chk("flush_ctrl", 8'h14, 32'h3);

    // capture disabled
    wr(8'h14, 4'h1, 32'h2);
    pulse(8'h44, 32'h4444, 12'h4);
    rd_chk("disabled_status", 8'h04, 32'h0001_0000);
    rd_chk("disabled_overflow", 8'h10, 32'h0);
    check("disabled_irq", 32'(irq), 32'd0);

    wr(8'h14, 4'h1, 32'h3);
    pulse(8'h55, 32'h5555, 12'h5);
    check("irq_next_cycle", 32'(irq), 32'd1);
    acc(8'h0C, 4'h0, 32'h0, 1'b0, r);
    check("irq_pop_value", r, 32'h5500_0005);
    check("irq_fall", 32'(irq), 32'd0);

    // reset in the middle of an access
    b.valid = 1'b1; b.addr = 32'h0300_0000; b.wstrb = 4'h0;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("reset_mid_ready", 32'(b.ready), 32'd0);
    b.valid = 1'b0;
    resetn = 1'b1;
    check("reset_mid_gpio", gpio_out, 32'h0);
    rd_chk("reset_mid_ctrl", 8'h14, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iomem_spi_log.md
# iomem_spi_log

Memory-mapped capture peripheral for the picosoc `iomem` bus that records SPI command events from the spy core into a parametrised FIFO and exposes them, plus a 32-bit GPIO register and an interrupt line, to firmware. It replaces the inline GPIO register in the top level and is the successor of that register. It adds:
- a configurable base address;
- a command log of configurable depth;
- overflow accounting, flush and an interrupt.

## Interface
Parameters:
- `BASE` (default 8'h03): matched against `iomem_addr[31:24]`.
- `DEPTH` (default 16): FIFO entries; power of two, 2..256.

Ports:
- `clk`  in  1  single system clock (picosoc clock).
- `resetn`  in  1  synchronous, active-low reset.
- `iomem_valid`  in  1  bus request.
- `iomem_ready`  out  1  one-cycle acknowledge.
- `iomem_wstrb`  in  4  byte write strobes; 0 = read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  read data; valid while `iomem_ready` is 1.
- `cmd_strobe`  in  1  one-cycle pulse per captured SPI command, already in the `clk` domain.
- `cmd`  in  8  SPI opcode; sampled with `cmd_strobe`.
- `cmd_addr`  in  32  SPI address; sampled with `cmd_strobe`.
- `cmd_len`  in  12  transfer length; sampled with `cmd_strobe`.
- `gpio_out`  out  32  GPIO register contents.
- `irq`  out  1  registered interrupt request.

## Operation
- Decode: the block is selected when `iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE`. Register index is `iomem_addr[4:2]`.
- Non-matching addresses: the block never asserts `iomem_ready`.
- Register map (offset, access, contents):
  - 0x00 GPIO, RW: per-byte write via `wstrb`.
  - 0x04 STATUS, RO: [15:0] count, [16] empty, [17] full.
  - 0x08 HEAD_ADDR, RO: `cmd_addr` of the head entry; non-destructive peek.
  - 0x0C HEAD_CMD, RO with pop: {cmd[31:24], 12'b0, len[11:0]}; a read pops the head.
  - 0x10 OVERFLOW, R/clear: number of dropped strobes; any write clears it to 0.
  - 0x14 CTRL, RW: [0] capture enable, [1] irq enable. Writing [31]=1 flushes the FIFO; bit 31 always reads 0.
  - 0x18, 0x1C: read 0; writes ignored; still acknowledged.
- Register writes apply only where the `wstrb` byte is set; a write to an RO register is acknowledged and has no effect.
- Push: `cmd_strobe && CTRL[0]` stores {cmd, cmd_addr, cmd_len} at the write pointer.
- Strobes with capture disabled are ignored and not counted.
- Full: a push is dropped and OVERFLOW increments, saturating at 32'hFFFF_FFFF.
- Pop on empty: HEAD_CMD returns 0 and the pointers are unchanged. HEAD_ADDR on empty returns 0.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, pop-then-push succeeds (no overflow).
  - When empty, the pop returns 0 and the push lands.
- Flush clears pointers and count in the write cycle; a push in the same cycle is dropped and not counted as overflow.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits wide, zero-extended into STATUS.
- `irq` is registered as `CTRL[1] && !empty`.
- Reset (`resetn` low at a `clk` edge):
  - FIFO empty;
  - OVERFLOW = 0;
  - GPIO = 0;
  - CTRL = 32'h1;
  - `iomem_ready` = 0;
  - `iomem_rdata` = 0;
  - `irq` = 0.
- Reset mid-transaction drops the access; the master retries.

## Timing
- Access latency: selection at cycle N gives `iomem_ready`=1 and `iomem_rdata` valid in cycle N+1. Ready deasserts in N+2.
- Back-to-back accesses: at most one access per two cycles.
- Register-write and pop effects are visible from cycle N+1.
- Push: strobe in cycle N gives STATUS.count updated and HEAD readable from cycle N+1. A STATUS read selected in cycle N+1 reports the new count.
- `irq`: rises one cycle after the first push, with irq enabled. Falls one cycle after the pop that empties the FIFO.
- The RAM may be inferred as BRAM; the head word must still be returned with the one-cycle latency above.

## Test plan
- Reset, then read 0x04 and 0x14 → STATUS 32'h0001_0000 and CTRL 32'h1. `gpio_out`=0 and `irq`=0.
- Write 0x00 with `wstrb`=4'b0101 and data 32'hAABBCCDD → `gpio_out`=32'h00BB00DD. Read back returns the same value with ready exactly one cycle after valid.
- Push cmd 8'h03, addr 32'h0012_3400, len 12'h100, then read 0x08, 0x0C, 0x04:
  - 0x08 → 32'h0012_3400;
  - 0x0C → 32'h0300_0100;
  - 0x04 → 32'h0001_0000 (empty again).
- DEPTH=16: push 20 strobes → STATUS 32'h0002_0010, OVERFLOW = 4. Popping all 16 returns the first 16 in order (pointer wrap checked).
- With the FIFO full, push and pop in the same cycle → count stays 16 and OVERFLOW is unchanged. Write 0x14 with 32'h8000_0003 → empty, `irq` low next cycle.
- Set CTRL = 32'h2 and issue a strobe → no push, OVERFLOW = 0. Set CTRL = 32'h3 and push → `irq` is 1 from the next cycle.
